// File: rtl/calc_operand_sequencer.sv
// rtl/calc_operand_sequencer.sv - strobe-driven operand loader and result presenter for the ALU
module calc_operand_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic [3:0] op_in,
  input  logic [7:0] data_in,
  input  logic [7:0] alu_y,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_sel,
  output logic [7:0] data_out,
  output logic [7:0] io_oe,
  output logic [3:0] status,
  output logic [2:0] op_count
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    EXEC   = 2'd2,
    SHOW   = 2'd3
  } state_t;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist;
  logic                   evt;
  logic                   tmo_hit;
  logic [31:0]            tmo_cnt;
  logic                   tmo_flag;
  logic                   zero_flag;

  // Chain and history reset high so a switch already closed at reset is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      hist   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
      hist   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign evt     = sync_q[SYNC_STAGES-1] & ~hist;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_A: if (evt) state_nxt = WAIT_B;
      WAIT_B: begin
        if (evt)          state_nxt = EXEC;
        else if (tmo_hit) state_nxt = WAIT_A;
      end
      EXEC:   state_nxt = SHOW;
      SHOW:   if (evt) state_nxt = WAIT_A;
      default: state_nxt = WAIT_A;
    endcase
  end

  // Bus capture happens only in WAIT_A/WAIT_B, so the driven result is never read back.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      data_out  <= '0;
      io_oe     <= '0;
      op_count  <= '0;
      tmo_cnt   <= '0;
      tmo_flag  <= 1'b0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        WAIT_A: if (evt) begin
          alu_a    <= data_in;
          tmo_flag <= 1'b0;
          tmo_cnt  <= '0;
        end
        WAIT_B: begin
          if (evt) begin
            alu_b   <= data_in;
            alu_sel <= op_in;
          end else if (tmo_hit) begin
            tmo_flag <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        EXEC: begin
          data_out  <= alu_y;
          zero_flag <= (alu_y == 8'h00);
          io_oe     <= 8'hFF;
          op_count  <= op_count + 3'd1;
        end
        SHOW: if (evt) io_oe <= 8'h00;
        default: ;
      endcase
    end
  end

  assign status = {zero_flag, tmo_flag, state};

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// tb/tb_calc_operand_sequencer.sv - scoreboard bench for calc_operand_sequencer
module tb_calc_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       strobe;
  logic [3:0] op_in;
  logic [7:0] data_in;
  logic [7:0] alu_y;
  logic [7:0] alu_a, alu_b, data_out, io_oe;
  logic [3:0] alu_sel, status;
  logic [2:0] op_count;

  typedef struct {
    int         cyc;
    logic [7:0] y;
    logic       z;
    logic [2:0] cnt;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] prev_oe  = 8'h00;
  logic [2:0] exp_cnt;

  calc_operand_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .op_in(op_in), .data_in(data_in),
    .alu_y(alu_y), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .data_out(data_out), .io_oe(io_oe), .status(status), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU
  always_comb begin
    case (alu_sel)
      4'd0:    alu_y = alu_a + alu_b;
      4'd1:    alu_y = alu_a - alu_b;
      4'd2:    alu_y = alu_a & alu_b;
      4'd3:    alu_y = alu_a ^ alu_b;
      default: alu_y = alu_a;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (io_oe == 8'hFF && prev_oe != 8'hFF) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h expected=none", data_out);
      end else begin
        mon_e = sb.pop_front();
        chk("oe_cycle", cyc, mon_e.cyc);
        chk("data_out", data_out, mon_e.y);
        chk("zero_flag", status[3], mon_e.z);
        chk("op_count", op_count, mon_e.cnt);
        chk("alu_a", alu_a, mon_e.a);
        chk("alu_b", alu_b, mon_e.b);
        chk("alu_sel", alu_sel, mon_e.sel);
      end
    end
    prev_oe <= io_oe;
  end

  // Raise the strobe so that the resulting load lands on edge load_edge.
  task automatic pulse(input int load_edge);
    while (cyc < load_edge - 3) begin
      @(posedge clk);
      #1;
    end
    strobe = 1'b1;
    repeat (3) @(posedge clk);
    #1 strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [7:0] a);
    data_in = a;
    pulse(cyc + 3);
  endtask

  // EXEC occupies one cycle, so io_oe rises on the edge after the B load.
  task automatic load_b(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic [7:0] y, input logic z, input int load_edge);
    exp_t e;
    data_in = b;
    op_in   = op;
    exp_cnt = exp_cnt + 3'd1;
    e.cyc = load_edge + 1;
    e.y   = y;
    e.z   = z;
    e.cnt = exp_cnt;
    e.a   = a;
    e.b   = b;
    e.sel = op;
    sb.push_back(e);
    pulse(load_edge);
  endtask

  task automatic exit_show(input logic [7:0] y);
    data_in = 8'h5A;
    pulse(cyc + 3);
    chk("exit_state", status[1:0], 2'd0);
    chk("exit_oe", io_oe, 8'h00);
    chk("exit_data_kept", data_out, y);
  endtask

  task automatic full_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [7:0] y, input logic z);
    load_a(a);
    load_b(a, b, op, y, z, cyc + 3);
    exit_show(y);
  endtask

  logic [7:0] t6_a[8] = '{8'h01, 8'hFF, 8'h80, 8'hAA, 8'hAA, 8'h3C, 8'h09, 8'h44};
  logic [7:0] t6_b[8] = '{8'h01, 8'h01, 8'h01, 8'h55, 8'h55, 8'h0F, 8'h04, 8'h44};
  logic [3:0] t6_o[8] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd3};
  logic [7:0] t6_y[8] = '{8'h02, 8'h00, 8'h7F, 8'h00, 8'hFF, 8'h0C, 8'h05, 8'h00};
  logic       t6_z[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int l;
    rst     = 1'b1;
    strobe  = 1'b1;
    data_in = 8'hAA;
    op_in   = 4'hF;
    exp_cnt = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", status, 4'h0);
    chk("rst_io_oe", io_oe, 8'h00);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_op_count", op_count, 3'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t1_state", status[1:0], 2'd0);
    chk("t1_no_capture", alu_a, 8'h00);
    strobe = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    full_op(8'h11, 8'h22, 4'd0, 8'h33, 1'b0);
    full_op(8'h55, 8'h55, 4'd1, 8'h00, 1'b1);
    full_op(8'h0F, 8'hF0, 4'd3, 8'hFF, 1'b0);

    // Timeout: A loaded at edge l, no strobe, back to WAIT_A on edge l+8
    data_in = 8'h77;
    l = cyc + 3;
    pulse(l);
    while (cyc < l + 7) begin
      @(posedge clk);
      #1;
    end
    chk("t4_pre_timeout_state", status[1:0], 2'd1);
    @(posedge clk);
    #1;
    chk("t4_timeout_state", status[1:0], 2'd0);
    chk("t4_timeout_flag", status[2], 1'b1);
    chk("t4_alu_a_kept", alu_a, 8'h77);
    load_a(8'h12);
    chk("t4_flag_cleared", status[2], 1'b0);
    chk("t4_state_b", status[1:0], 2'd1);
    load_b(8'h12, 8'h34, 4'd2, 8'h10, 1'b0, cyc + 3);
    exit_show(8'h10);

    // Event on the timeout edge wins
    data_in = 8'hC8;
    l = cyc + 3;
    pulse(l);
    load_b(8'hC8, 8'h38, 4'd0, 8'h00, 1'b1, l + 8);
    chk("t5_state_show", status[1:0], 2'd3);
    chk("t5_no_timeout", status[2], 1'b0);
    exit_show(8'h00);

    for (int i = 0; i < 8; i++) begin
      load_a(t6_a[i]);
      load_b(t6_a[i], t6_b[i], t6_o[i], t6_y[i], t6_z[i], cyc + 3);
      if (i != 7) exit_show(t6_y[i]);
    end
    chk("t6_in_show", status[1:0], 2'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_rst_io_oe", io_oe, 8'h00);
    chk("t6_rst_status", status, 4'h0);
    chk("t6_rst_data_out", data_out, 8'h00);
    chk("t6_rst_op_count", op_count, 3'd0);
    chk("t6_rst_operands", {alu_a, alu_b, alu_sel}, 20'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
